// File: rtl/chroma_key_mixer.sv
// rtl/chroma_key_mixer.sv - chroma-key compositor joining a foreground and a background pixel stream
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   fg_data/valid/sop/eop, fg_ready     foreground (camera) stream in
//   bg_data/valid/sop/eop, bg_ready     background (frame buffer) stream in
//   out_data/valid/sop/eop, out_ready   composited stream out
//   cfg_key, cfg_tol, cfg_mode          key colour, per-channel tolerance, output mode
//   keyed_count                         keyed pixels in the last completed frame
//   err_count                           saturating count of resync events
module chroma_key_mixer #(
    parameter int CW    = 8,
    parameter int CNT_W = 20,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3*CW-1:0]   fg_data,
    input  logic              fg_valid,
    input  logic              fg_sop,
    input  logic              fg_eop,
    output logic              fg_ready,
    input  logic [3*CW-1:0]   bg_data,
    input  logic              bg_valid,
    input  logic              bg_sop,
    input  logic              bg_eop,
    output logic              bg_ready,
    output logic [3*CW-1:0]   out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    input  logic [3*CW-1:0]   cfg_key,
    input  logic [CW-1:0]     cfg_tol,
    input  logic [1:0]        cfg_mode,
    output logic [CNT_W-1:0]  keyed_count,
    output logic [ERR_W-1:0]  err_count
);
    localparam int PW = 3 * CW;

    typedef enum logic {SYNC, RUN} state_t;
    state_t state;

    // Frame-atomic configuration shadow
    logic [PW-1:0] sh_key;
    logic [CW-1:0] sh_tol;
    logic [1:0]    sh_mode;

    // Stage 1: joined pixel pair plus key decision
    logic          s1_valid, s1_sop, s1_eop, s1_keyed;
    logic [PW-1:0] s1_fg, s1_bg;
    logic [1:0]    s1_mode;

    logic [CNT_W-1:0] cnt;

    logic adv, both_valid, join_beat, mismatch, take;
    logic [PW-1:0] eff_key;
    logic [CW-1:0] eff_tol;
    logic [1:0]    eff_mode;
    logic          in_keyed;
    logic [CNT_W-1:0] cnt_next;

    // |a - b| <= t, evaluated with one extra bit so the sign is visible
    function automatic logic chan_ok(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                     input logic [CW-1:0] t);
        logic [CW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[CW]) d = -d;
        return d <= {1'b0, t};
    endfunction

    always_comb begin
        adv        = !out_valid || out_ready;
        both_valid = fg_valid && bg_valid;
        join_beat  = (state == RUN) && adv && both_valid;
        mismatch   = join_beat && ((fg_sop != bg_sop) || (fg_eop != bg_eop));
        take       = join_beat && !mismatch;

        if (state == SYNC) begin
            // Drain beats that cannot start a frame; hold a stream parked on sop
            fg_ready = fg_valid && !fg_sop;
            bg_ready = bg_valid && !bg_sop;
        end else begin
            fg_ready = adv && both_valid;
            bg_ready = adv && both_valid;
        end

        // The sop beat already uses the configuration it is about to latch
        eff_key  = fg_sop ? cfg_key  : sh_key;
        eff_tol  = fg_sop ? cfg_tol  : sh_tol;
        eff_mode = fg_sop ? cfg_mode : sh_mode;

        in_keyed = chan_ok(fg_data[3*CW-1:2*CW], eff_key[3*CW-1:2*CW], eff_tol) &&
                   chan_ok(fg_data[2*CW-1:CW],   eff_key[2*CW-1:CW],   eff_tol) &&
                   chan_ok(fg_data[CW-1:0],      eff_key[CW-1:0],      eff_tol);

        cnt_next = s1_sop ? {{(CNT_W-1){1'b0}}, s1_keyed}
                          : cnt + {{(CNT_W-1){1'b0}}, s1_keyed};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC;
            sh_key      <= '0;
            sh_tol      <= '0;
            sh_mode     <= '0;
            s1_valid    <= 1'b0;
            s1_sop      <= 1'b0;
            s1_eop      <= 1'b0;
            s1_keyed    <= 1'b0;
            s1_fg       <= '0;
            s1_bg       <= '0;
            s1_mode     <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= '0;
            cnt         <= '0;
            keyed_count <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                SYNC: if (both_valid && fg_sop && bg_sop) state <= RUN;
                RUN: begin
                    if (mismatch) begin
                        state <= SYNC;
                        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                    end else if (take && fg_eop) begin
                        state <= SYNC;
                    end
                end
                default: state <= SYNC;
            endcase

            if (take && fg_sop) begin
                sh_key  <= cfg_key;
                sh_tol  <= cfg_tol;
                sh_mode <= cfg_mode;
            end

            if (adv) begin
                s1_valid <= take;
                if (take) begin
                    s1_fg    <= fg_data;
                    s1_bg    <= bg_data;
                    s1_sop   <= fg_sop;
                    s1_eop   <= fg_eop;
                    s1_keyed <= in_keyed;
                    s1_mode  <= eff_mode;
                end

                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_sop <= s1_sop;
                    out_eop <= s1_eop;
                    case (s1_mode)
                        2'd0:    out_data <= s1_fg;
                        2'd1:    out_data <= s1_bg;
                        2'd2:    out_data <= s1_keyed ? s1_bg : s1_fg;
                        default: out_data <= {PW{s1_keyed}};
                    endcase
                    // An aborted frame never gets its eop out of S1, so it never publishes
                    cnt <= cnt_next;
                    if (s1_eop) keyed_count <= cnt_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_chroma_key_mixer.sv
// tb/tb_chroma_key_mixer.sv - scoreboard bench for chroma_key_mixer
module tb_chroma_key_mixer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] fg_data, bg_data, out_data, cfg_key;
    logic        fg_valid, fg_sop, fg_eop, fg_ready;
    logic        bg_valid, bg_sop, bg_eop, bg_ready;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [7:0]  cfg_tol;
    logic [1:0]  cfg_mode;
    logic [19:0] keyed_count;
    logic [7:0]  err_count;

    chroma_key_mixer #(.CW(8), .CNT_W(20), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .fg_data(fg_data), .fg_valid(fg_valid), .fg_sop(fg_sop), .fg_eop(fg_eop), .fg_ready(fg_ready),
        .bg_data(bg_data), .bg_valid(bg_valid), .bg_sop(bg_sop), .bg_eop(bg_eop), .bg_ready(bg_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .cfg_key(cfg_key), .cfg_tol(cfg_tol), .cfg_mode(cfg_mode),
        .keyed_count(keyed_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc = -1;
    int first_out = -1;
    logic lat_arm = 1'b0;
    logic [25:0] sbq[$];

    logic [23:0] F1  [4] = '{24'h00F000, 24'h00FF00, 24'hFF0000, 24'h10EF10};
    logic [23:0] F4  [4] = '{24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00};
    logic [23:0] B1  [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    // Expected beats: {pixel, sop, eop}
    logic [25:0] E1  [4] = '{{24'h111111, 2'b10}, {24'h222222, 2'b00},
                             {24'hFF0000, 2'b00}, {24'h444444, 2'b01}};
    logic [25:0] EBG [4] = '{{24'h111111, 2'b10}, {24'h222222, 2'b00},
                             {24'h333333, 2'b00}, {24'h444444, 2'b01}};
    logic [25:0] EM3 [4] = '{{24'h000000, 2'b10}, {24'hFFFFFF, 2'b00},
                             {24'h000000, 2'b00}, {24'h000000, 2'b01}};
    logic [25:0] EM0 [4] = '{{24'h00F000, 2'b10}, {24'h00FF00, 2'b00},
                             {24'hFF0000, 2'b00}, {24'h10EF10, 2'b01}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every beat the DUT hands over is matched against the scoreboard head
    initial forever begin
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
            if (lat_arm && first_out < 0) first_out = cyc;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h expected none", out_data);
            end else begin
                chk("out_beat", {out_data, out_sop, out_eop}, sbq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Present one beat and wait until the selected streams accept it
    task automatic beat(input logic fv, input logic [23:0] fd, input logic fs, input logic fe,
                        input logic bv, input logic [23:0] bd, input logic bs, input logic be,
                        input logic wf, input logic wb, output logic fr, output logic br);
        int n;
        n = 0;
        fg_valid = fv; fg_data = fd; fg_sop = fs; fg_eop = fe;
        bg_valid = bv; bg_data = bd; bg_sop = bs; bg_eop = be;
        forever begin
            @(negedge clk);
            if ((!wf || fg_ready) && (!wb || bg_ready)) break;
            n++;
            if (n > 50) begin
                chk("beat_timeout", 32'd1, 32'd0);
                break;
            end
        end
        fr = fg_ready;
        br = bg_ready;
        if (lat_arm && first_acc < 0) first_acc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fg_valid = 1'b0; bg_valid = 1'b0;
        fg_sop = 1'b0; fg_eop = 1'b0; bg_sop = 1'b0; bg_eop = 1'b0;
    endtask

    task automatic frame(input logic [23:0] fd [4], input logic [23:0] bd [4],
                         input logic [1:0] mode, input logic [7:0] tol,
                         input logic [1:0] late_mode, input int late_at,
                         input logic [25:0] exp [4]);
        logic fr, br;
        cfg_key = 24'h00FF00; cfg_tol = tol; cfg_mode = mode;
        for (int i = 0; i < 4; i++) sbq.push_back(exp[i]);
        for (int i = 0; i < 4; i++) begin
            if (i == late_at) cfg_mode = late_mode;
            beat(1'b1, fd[i], i == 0, i == 3, 1'b1, bd[i], i == 0, i == 3, 1'b1, 1'b1, fr, br);
        end
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic fr, br;
        reset_n = 1'b0; out_ready = 1'b1;
        cfg_key = '0; cfg_tol = '0; cfg_mode = '0;
        fg_data = '0; bg_data = '0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", {out_data, out_sop, out_eop}, 0);
        chk("rst_ready", {fg_ready, bg_ready}, 0);
        chk("rst_counts", {keyed_count, err_count}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic keyed frame and latency
        lat_arm = 1'b1;
        frame(F1, B1, 2'd2, 8'd16, 2'd2, 99, E1);
        drain();
        lat_arm = 1'b0;
        chk("latency", first_out - first_acc, 2);
        chk("keyed_basic", keyed_count, 3);

        // Downstream stall: output held, inputs back-pressured
        fork
            frame(F1, B1, 2'd2, 8'd16, 2'd2, 99, E1);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                chk("stall_start", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_hold", {out_valid, out_data, out_sop, out_eop}, {1'b1, E1[1]});
                    chk("stall_ready", {fg_ready, bg_ready}, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("keyed_stall", keyed_count, 3);

        // Mid-frame mode change applies only to the following frame
        frame(F1, B1, 2'd2, 8'd16, 2'd1, 2, E1);
        frame(F1, B1, 2'd1, 8'd16, 2'd1, 99, EBG);
        drain();
        chk("keyed_mode1", keyed_count, 3);

        // Foreground starts mid-frame: two stray beats discarded while bg waits on sop
        beat(1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b1, B1[0], 1'b1, 1'b0, 1'b1, 1'b0, fr, br);
        chk("stray1_bg_held", br, 0);
        beat(1'b1, 24'h123456, 1'b0, 1'b1, 1'b1, B1[0], 1'b1, 1'b0, 1'b1, 1'b0, fr, br);
        chk("stray2_bg_held", br, 0);
        frame(F4, B1, 2'd2, 8'd16, 2'd2, 99, EBG);
        drain();
        chk("stray_err", err_count, 0);
        chk("keyed_all", keyed_count, 4);

        // bg ends early: resync, aborted frame does not publish a count
        sbq.push_back(E1[0]);
        sbq.push_back(E1[1]);
        beat(1'b1, F1[0], 1'b1, 1'b0, 1'b1, B1[0], 1'b1, 1'b0, 1'b1, 1'b1, fr, br);
        beat(1'b1, F1[1], 1'b0, 1'b0, 1'b1, B1[1], 1'b0, 1'b0, 1'b1, 1'b1, fr, br);
        beat(1'b1, F1[2], 1'b0, 1'b0, 1'b1, B1[2], 1'b0, 1'b1, 1'b1, 1'b1, fr, br);
        beat(1'b1, F1[3], 1'b0, 1'b1, 1'b1, B1[0], 1'b1, 1'b0, 1'b1, 1'b0, fr, br);
        chk("resync_bg_held", br, 0);
        idle();
        drain();
        chk("resync_err", err_count, 1);
        chk("resync_keyed_kept", keyed_count, 4);
        frame(F1, B1, 2'd2, 8'd16, 2'd2, 99, E1);
        drain();
        chk("resync_next_keyed", keyed_count, 3);

        // Tolerance boundaries and the remaining modes
        frame(F1, B1, 2'd3, 8'd0, 2'd3, 99, EM3);
        drain();
        chk("keyed_tol0", keyed_count, 1);
        frame(F1, B1, 2'd0, 8'hFF, 2'd0, 99, EM0);
        drain();
        chk("keyed_tolmax", keyed_count, 4);

        // Single-pixel frame
        cfg_key = 24'h00FF00; cfg_tol = 8'd16; cfg_mode = 2'd1;
        sbq.push_back({24'h111111, 2'b11});
        beat(1'b1, 24'h00FF00, 1'b1, 1'b1, 1'b1, 24'h111111, 1'b1, 1'b1, 1'b1, 1'b1, fr, br);
        idle();
        drain();
        chk("keyed_1px", keyed_count, 1);

        // Asynchronous reset with a beat on the output
        cfg_mode = 2'd2;
        sbq.push_back(E1[0]);
        sbq.push_back(E1[1]);
        beat(1'b1, F1[0], 1'b1, 1'b0, 1'b1, B1[0], 1'b1, 1'b0, 1'b1, 1'b1, fr, br);
        beat(1'b1, F1[1], 1'b0, 1'b0, 1'b1, B1[1], 1'b0, 1'b0, 1'b1, 1'b1, fr, br);
        chk("pre_reset_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_valid", {out_valid, out_sop, out_eop}, 0);
        chk("areset_counts", {keyed_count, err_count}, 0);
        sbq.delete();
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        frame(F1, B1, 2'd2, 8'd16, 2'd2, 99, E1);
        drain();
        chk("post_reset_keyed", keyed_count, 3);
        chk("post_reset_err", err_count, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chroma_key_mixer.md
Name: chroma_key_mixer

Overview:
- Parametrised Avalon-ST video compositor. It joins a foreground stream (camera, from the video decoder path) with a background stream (frame buffer) pixel by pixel.
- Each foreground pixel whose colour lies within a per-channel tolerance of the key colour is replaced by the background pixel.
- Output feeds the MTL/VGA pixel path.
- Adds three things: generic colour width, frame-atomic configuration shadowing, and stream resynchronisation with error and keyed-pixel statistics.

Parameters:
- CW, 8, bits per colour channel; pixel is 3*CW bits, R in MSBs, then G, then B.
- CNT_W, 20, width of the keyed-pixel counter.
- ERR_W, 8, width of the saturating resync-error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- fg_data  in  3*CW  foreground pixel.
- fg_valid  in  1  foreground beat valid.
- fg_sop  in  1  foreground start of frame.
- fg_eop  in  1  foreground end of frame.
- fg_ready  out  1  foreground accept.
- bg_data  in  3*CW  background pixel.
- bg_valid  in  1  background beat valid.
- bg_sop  in  1  background start of frame.
- bg_eop  in  1  background end of frame.
- bg_ready  out  1  background accept.
- out_data  out  3*CW  composited pixel.
- out_valid  out  1  output beat valid.
- out_sop  out  1  output start of frame.
- out_eop  out  1  output end of frame.
- out_ready  in  1  downstream accept.
- cfg_key  in  3*CW  key colour.
- cfg_tol  in  CW  per-channel tolerance.
- cfg_mode  in  2  0 fg pass, 1 bg pass, 2 key, 3 key-mask (keyed=all ones, else all zeros).
- keyed_count  out  CNT_W  keyed pixels in last completed frame.
- err_count  out  ERR_W  resync events, saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=SYNC; out_valid/out_sop/out_eop=0; out_data=0; fg_ready/bg_ready=0; keyed_count=0; err_count=0; shadow config=0 (mode 0).
- Beat transfer: valid&&ready in the same cycle; readyLatency 0.
- Pipeline: 2 register stages (S1 compare, S2 output). Global advance adv = !out_valid || out_ready.
  - On adv, S1 moves to S2 and an accepted join enters S1.
  - On !adv, all stages hold and out_data/out_sop/out_eop remain stable.
  - Latency: accept to out_valid = 2 cycles when unstalled; throughput 1 pixel/cycle.
- State SYNC:
  - A stream whose head beat has sop=0 gets ready=1 and that beat is discarded.
  - A stream whose head has sop=1 gets ready=0 and is held.
  - When both heads show sop=1, go to RUN; no beat is consumed in that cycle.
- State RUN:
  - fg_ready=bg_ready=adv&&fg_valid&&bg_valid; both streams are always consumed together.
  - On a joined beat with fg_sop!=bg_sop or fg_eop!=bg_eop: both beats are dropped, err_count++ (saturates at all ones), state goes to SYNC. Any S1/S2 content still drains normally.
  - A joined beat with both eop=1 is passed through, then state returns to SYNC.
- Config shadow: cfg_key/cfg_tol/cfg_mode are latched only on the joined sop beat and apply from that pixel to eop. Mid-frame cfg changes have no effect.
- Key test: per channel |fg_c - key_c| <= tol, unsigned with CW+1-bit difference. keyed = all three channels pass. tol=0 requires an exact match; tol=all-ones keys every pixel.
- Output select:
  - mode0 fg.
  - mode1 bg.
  - mode2 keyed?bg:fg.
  - mode3 {3*CW{keyed}}.
- sop/eop travel with their pixel.
- Statistics:
  - Internal counter clears on the sop beat (loads keyed?1:0) and increments per keyed beat, wrapping at 2^CNT_W.
  - keyed_count takes the final value on the eop beat leaving S1.
  - A frame aborted by resync does not update keyed_count.
  - Counting happens in modes 0-3 alike.
- Simultaneous events: a sop beat that also has eop (1-pixel frame) is a valid frame; config is latched, keyed_count updated, state goes to SYNC.
- Reset mid-frame: everything returns to reset values immediately and pipeline contents are lost.

Test Plan:
- CW=8, key=00FF00, tol=16, mode2, 4-pixel frames, fg={00F000,00FF00,FF0000,10EF10}, bg={111111,222222,333333,444444}.
  - out={111111,222222,FF0000,444444}; out_sop on beat0, out_eop on beat3; keyed_count=3; first out_valid 2 cycles after first accept.
- Same frame with out_ready low on cycles 3-6: out_data/sop/eop held stable; fg/bg_ready=0 while stalled; no beat lost or duplicated.
- cfg_mode changed 2->1 at pixel 2 of a frame: current frame stays keyed; the next frame is a pure bg pass.
- fg lacks sop (starts mid-frame with 2 stray beats): 2 fg beats discarded in SYNC, bg held; output frame aligned; err_count=0.
- bg_eop on pixel 2 while fg_eop is on pixel 3: err_count=1; SYNC entered; next aligned frame outputs correctly; keyed_count unchanged from the previous frame.
- reset_n pulsed low mid-frame with out_valid=1: out_valid drops within the same cycle asynchronously; counters are 0; the next full frame composites correctly.
